// File: rtl/rmii_rx_gen.sv
// rmii_rx_gen: RMII (DW=2) / MII (DW=4) receive front end with preamble/SFD qualification,
// byte assembly, length limiting and error flags. Define RMII_RX_GEN_CRC_CHECK_EN for the FCS check.
module rmii_rx_gen #(
    parameter int DW      = 2,
    parameter int CNT_W   = 16,
    parameter int MIN_PRE = 8,
    parameter int MAX_LEN = 1522,
    parameter int IFG_SYM = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic [DW-1:0]    rxd,
    input  logic             crs_dv,
    input  logic             rx_er,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    output logic             byte_last,
    output logic [CNT_W-1:0] byte_count,
    output logic             frame_start,
    output logic             frame_end,
    output logic             frame_err,
    output logic             err_align,
    output logic             err_len,
    output logic             err_rxer,
    output logic             err_fcs
);
    localparam int SPB = 8 / DW;
    localparam int SW  = $clog2(SPB);
    localparam int PW  = $clog2(MIN_PRE + 1);
    localparam int GW  = $clog2(IFG_SYM + 1);
    localparam logic [DW-1:0] PRE_SYM = (DW == 4) ? DW'(5) : DW'(1);

    typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} state_t;
    state_t state, state_nxt;

    logic          se_q, crs_q, rer_q;
    logic [DW-1:0] rxd_q;
    logic [7:0]    sh, sh_nxt, hold;
    logic          hold_full, low_seen, discard;
    logic [SW-1:0] sym_cnt;
    logic [PW-1:0] pre_cnt;
    logic [GW-1:0] gap_cnt;

    logic is_pre, tick_data, sym_last, sfd_ok, len_full, end_now, emit_mid;
    logic align_end, rxer_nxt, fcs_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            se_q  <= 1'b0;
            crs_q <= 1'b0;
            rer_q <= 1'b0;
            rxd_q <= '0;
        end else begin
            se_q  <= sample_en;
            crs_q <= crs_dv;
            rer_q <= rx_er;
            rxd_q <= rxd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (se_q && crs_q && is_pre) state_nxt = PRE;
            PRE: begin
                if (se_q) begin
                    if (sfd_ok)                 state_nxt = DATA;
                    else if (!crs_q || !is_pre) state_nxt = IDLE;
                end
            end
            DATA: if (end_now) state_nxt = GAP;
            GAP:  if (se_q && gap_cnt == GW'(IFG_SYM - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Per-sample decode shared by the datapath and the CRC.
    always_comb begin
        sh_nxt    = {rxd_q, sh[7:DW]};
        is_pre    = (rxd_q == PRE_SYM);
        tick_data = se_q && (state == DATA);
        sym_last  = &sym_cnt;
        sfd_ok    = se_q && (state == PRE) && crs_q && !is_pre &&
                    (sh_nxt == 8'hD5) && (pre_cnt >= PW'(MIN_PRE));
        len_full  = ({1'b0, byte_count} + (CNT_W+1)'(hold_full)) >= (CNT_W+1)'(MAX_LEN);
        emit_mid  = tick_data && crs_q && sym_last && !discard && !len_full && hold_full;
        end_now   = tick_data && !crs_q && low_seen;
        align_end = (sym_cnt != '0) || (!hold_full && (byte_count == '0));
        rxer_nxt  = err_rxer || rer_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_out    <= '0;
            byte_valid  <= 1'b0;
            byte_last   <= 1'b0;
            byte_count  <= '0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            frame_err   <= 1'b0;
            err_align   <= 1'b0;
            err_len     <= 1'b0;
            err_rxer    <= 1'b0;
            err_fcs     <= 1'b0;
            sh          <= '0;
            hold        <= '0;
            hold_full   <= 1'b0;
            low_seen    <= 1'b0;
            discard     <= 1'b0;
            sym_cnt     <= '0;
            pre_cnt     <= '0;
            gap_cnt     <= '0;
        end else begin
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            byte_valid  <= 1'b0;
            byte_last   <= 1'b0;
            if (se_q) begin
                case (state)
                    IDLE: begin
                        sh      <= sh_nxt;
                        pre_cnt <= PW'(1);
                    end
                    PRE: begin
                        sh <= sh_nxt;
                        if (is_pre && pre_cnt < PW'(MIN_PRE)) pre_cnt <= pre_cnt + 1'b1;
                        if (sfd_ok) begin
                            frame_start <= 1'b1;
                            byte_count  <= '0;
                            sym_cnt     <= '0;
                            hold_full   <= 1'b0;
                            low_seen    <= 1'b0;
                            discard     <= 1'b0;
                            frame_err   <= 1'b0;
                            err_align   <= 1'b0;
                            err_len     <= 1'b0;
                            err_rxer    <= 1'b0;
                            err_fcs     <= 1'b0;
                        end
                    end
                    DATA: begin
                        if (rer_q) err_rxer <= 1'b1;
                        if (crs_q) begin
                            low_seen <= 1'b0;
                            sh       <= sh_nxt;
                            sym_cnt  <= sym_cnt + 1'b1;
                            if (sym_last && !discard) begin
                                if (len_full) begin
                                    err_len <= 1'b1;
                                    discard <= 1'b1;
                                end else begin
                                    hold      <= sh_nxt;
                                    hold_full <= 1'b1;
                                end
                            end
                            if (emit_mid) begin
                                byte_out   <= hold;
                                byte_valid <= 1'b1;
                                byte_count <= byte_count + 1'b1;
                            end
                        end else if (!low_seen) begin
                            low_seen <= 1'b1;
                        end else begin
                            // Second consecutive low sample closes the frame.
                            frame_end <= 1'b1;
                            gap_cnt   <= '0;
                            if (hold_full) begin
                                byte_out   <= hold;
                                byte_valid <= 1'b1;
                                byte_last  <= 1'b1;
                                byte_count <= byte_count + 1'b1;
                                hold_full  <= 1'b0;
                            end
                            err_align <= align_end;
                            err_fcs   <= fcs_bad;
                            frame_err <= align_end || err_len || rxer_nxt || fcs_bad;
                        end
                    end
                    GAP: gap_cnt <= gap_cnt + 1'b1;
                    default: ;
                endcase
            end
        end
    end

`ifdef RMII_RX_GEN_CRC_CHECK_EN
    logic [31:0] crc, crc_fin;

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // The reflected register holds the bit-reversed form of the standard residue.
    always_comb begin
        crc_fin = hold_full ? crc_upd(crc, hold) : crc;
        fcs_bad = (rev32(crc_fin) != 32'hC704DD7B);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                crc <= '0;
        else if (sfd_ok)                         crc <= '1;
        else if (emit_mid || (end_now && hold_full)) crc <= crc_upd(crc, hold);
    end
`else
    assign fcs_bad = 1'b0;
`endif

endmodule

// File: doc/rmii_rx_gen.md
Name: rmii_rx_gen

Overview:
Parametrised successor to the team's RMII byte receiver: one block covers RMII (2-bit) and MII (4-bit) symbol widths, selected by parameter.
- Preamble qualification, SFD detection, byte assembly with valid/last handshake, length limiting, alignment/error reporting and an inter-frame gap.
- Sits between the PHY pins (already in the `clk` domain, qualified by `sample_en`) and the frame parser / FIFO.

Parameters:
- DW, 2, symbol width: 2 = RMII, 4 = MII; other values illegal.
- CNT_W, 16, width of byte_count.
- MIN_PRE, 8, minimum preamble symbols before the SFD symbol for a frame to be accepted.
- MAX_LEN, 1522, maximum bytes per frame; further bytes are dropped.
- IFG_SYM, 24, samples spent in GAP after frame end before SFD hunting resumes.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- sample_en  in  1  one-cycle strobe per line symbol
- rxd  in  DW  PHY receive data
- crs_dv  in  1  carrier sense / data valid
- rx_er  in  1  PHY receive error
- byte_out  out  8  received byte, LSB-first assembly
- byte_valid  out  1  one-cycle pulse: byte_out valid
- byte_last  out  1  with byte_valid: final byte of the frame
- byte_count  out  CNT_W  bytes emitted in the current frame
- frame_start  out  1  one-cycle pulse on SFD accept
- frame_end  out  1  one-cycle pulse at frame close
- frame_err  out  1  OR of all error flags; valid at frame_end, held until next frame_start
- err_align  out  1  frame ended with a partial byte
- err_len  out  1  MAX_LEN exceeded
- err_rxer  out  1  rx_er seen during DATA
- err_fcs  out  1  FCS mismatch (see Optional Feature)

Behaviour:
- Reset (`rst` = 0): all outputs 0, state IDLE, all counters and shift register cleared. Reset mid-frame discards the frame; no frame_end is issued.
- Input registering: rxd, crs_dv and rx_er are registered once on `clk`. All state updates use the registered values, and only on cycles with sample_en = 1.
- Shift register: sh <= {rxd_q, sh[7:DW]}, so the newest symbol enters at the MSBs.
- Pulses: frame_start, frame_end and byte_valid are exactly one `clk` wide and are cleared on the next cycle regardless of sample_en.
- IDLE: crs_q = 1 and the symbol equals the preamble pattern (DW=2: 2'b01, DW=4: 4'h5) -> PREAMBLE with pre_cnt = 1.
- PREAMBLE:
  - Preamble symbol -> pre_cnt+1, saturating.
  - Shifted value equals 8'hD5 with pre_cnt >= MIN_PRE -> DATA. Pulse frame_start; clear byte_count, sym_cnt and error flags.
  - D5 with a short preamble, any other symbol, or crs_q = 0 -> IDLE silently.
- DATA:
  - Shift only on samples with crs_q = 1; sym_cnt counts modulo 8/DW.
  - On byte completion the byte is placed in a one-deep hold register.
  - If the hold register was already full, its previous content is emitted (byte_valid = 1, byte_last = 0) and byte_count is incremented.
  - A single crs_q = 0 sample is tolerated (RMII carrier toggling near end of frame).
  - Frame ends on two consecutive crs_q = 0 samples. The held byte is then emitted with byte_last = 1 in the same cycle as frame_end, and the block enters GAP.
  - sym_cnt != 0 at end -> err_align = 1; partial bits are discarded.
  - Frame ends with zero bytes -> frame_end with frame_err = 1 and err_align = 1; no byte_valid.
- Length limit: a byte that would make byte_count exceed MAX_LEN is not emitted and sets err_len; the remainder of the frame is discarded. byte_count never exceeds MAX_LEN.
- err_rxer: set sticky by any rx_er_q = 1 sample in DATA.
- GAP: counts IFG_SYM samples ignoring the line, then -> IDLE. A crs_dv that is still high during GAP does not start a frame.
- Latency: from the sample completing byte N+1 (or frame end) to byte_valid for byte N = 2 `clk` cycles (input register + output register).

Optional Feature:
- Macro: RMII_RX_GEN_CRC_CHECK_EN.
- Defined: CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) is computed over every emitted byte, including the FCS. At frame_end, err_fcs = 1 if the residue is not 0xC704DD7B, and frame_err includes err_fcs.
- Undefined: no CRC logic; err_fcs tied to 0.

Test Plan:
- DW=2: 7x 0x55 + 0xD5, then 0x01 0x02 0x03, crs_dv low -> frame_start once; byte_valid x3 with 01, 02, 03; byte_last on 03; byte_count = 3; frame_err = 0.
- DW=4, MIN_PRE=8: 3 preamble symbols then SFD -> no frame_start; state back to IDLE. Full 15-symbol preamble + SFD -> frame_start.
- DW=2: frame 0xAA 0xBB, then one extra dibble and crs_dv low -> two bytes emitted, last = 0xBB; err_align = 1; frame_err = 1.
- MAX_LEN=4: 6-byte frame -> exactly 4 byte_valid; byte_count = 4; err_len = 1; last emitted byte flagged byte_last at frame end.
- rx_er pulsed mid-frame and single-sample crs_dv dropouts -> frame not split; err_rxer = 1. Reset asserted mid-frame -> all outputs 0 immediately; no frame_end.
- With RMII_RX_GEN_CRC_CHECK_EN defined: 60-byte frame with correct FCS -> err_fcs = 0. Same frame with one flipped bit -> err_fcs = 1 and frame_err = 1.
